// File: rtl/seq_detector_param.sv
// seq_detector_param
//
// Serial pattern detector. On each enabled clock one bit of A is shifted into
// a WIDTH-bit window. The window is compared against a pattern that can be
// reloaded at run time. Each match produces a one-cycle registered pulse on B
// and bumps a saturating match counter.
//
// Parameters:
//   WIDTH    pattern length in bits (2..16)
//   CNT_W    width of the match counter
//   OVERLAP  1: matches may share bits; 0: WIDTH fresh bits needed after a match
//   PAT_INIT pattern value loaded by reset
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   reset      synchronous, active-high reset (highest priority)
//   en         sample enable; 0 freezes all state and forces B low
//   A          serial data bit, MSB of the pattern arrives first
//   cfg_load   load `pattern` into the pattern register and restart detection
//   pattern    new pattern; the first received bit compares to pattern[WIDTH-1]
//   B          registered match pulse, one cycle wide
//   match_cnt  saturating count of matches
//   state      FSM state: 0 idle, 1 fill, 2 detect

module seq_detector_param #(
    parameter int unsigned      WIDTH    = 5,
    parameter int unsigned      CNT_W    = 8,
    parameter bit               OVERLAP  = 1'b1,
    parameter logic [WIDTH-1:0] PAT_INIT = WIDTH'(5'b00100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             A,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] pattern,
    output logic             B,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);

    // Fill counter must be able to hold the value WIDTH itself.
    localparam int unsigned      FW       = $clog2(WIDTH + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(WIDTH);
    // Once this many bits are in the window, the incoming bit completes it.
    localparam logic [FW-1:0]    FILL_RDY = FW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFill   = 2'd1,
        StDetect = 2'd2
    } state_e;

    // Elaboration-time guard on the supported pattern length.
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("seq_detector_param: WIDTH must be in 2..16");
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] pat_q,      pat_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;
    logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             b_q,        b_d;
    state_e           state_q,    state_d;

    // ------------------------------------------------------------------------
    // Match detection
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] win;
    logic             fill_ready;
    logic             match;
    logic             restart;   // non-overlap mode: window must refill after a match

    always_comb begin
        // Oldest bit sits in win[WIDTH-1], so the pattern reads MSB-first.
        win        = {shreg_q[WIDTH-2:0], A};
        // Gates out the reset zeros still sitting in the shift register.
        fill_ready = (fill_cnt_q >= FILL_RDY);
        match      = en && !cfg_load && fill_ready && (win == pat_q);
        restart    = match && !OVERLAP;
    end

    // ------------------------------------------------------------------------
    // State register (synchronous reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q      <= PAT_INIT;
            shreg_q    <= '0;
            fill_cnt_q <= '0;
            cnt_q      <= '0;
            b_q        <= 1'b0;
            state_q    <= StIdle;
        end else begin
            pat_q      <= pat_d;
            shreg_q    <= shreg_d;
            fill_cnt_q <= fill_cnt_d;
            cnt_q      <= cnt_d;
            b_q        <= b_d;
            state_q    <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        pat_d      = pat_q;
        shreg_d    = shreg_q;
        fill_cnt_d = fill_cnt_q;
        cnt_d      = cnt_q;
        b_d        = 1'b0;

        if (cfg_load) begin
            // The A bit presented with a load is dropped even when en=1.
            pat_d      = pattern;
            shreg_d    = '0;
            fill_cnt_d = '0;
            cnt_d      = '0;
        end else if (en) begin
            shreg_d = win;

            if (restart) begin
                fill_cnt_d = '0;
            end else if (fill_cnt_q < FILL_MAX) begin
                fill_cnt_d = fill_cnt_q + FW'(1);
            end

            if (match) begin
                b_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;

        if (cfg_load) begin
            state_d = StIdle;
        end else if (en) begin
            unique case (state_q)
                // The first enabled bit is sampled as it leaves idle; with
                // WIDTH >= 2 one bit can never complete the window.
                StIdle: state_d = StFill;

                StFill: begin
                    if (!restart && fill_cnt_d == FILL_MAX) begin
                        state_d = StDetect;
                    end
                end

                StDetect: begin
                    if (restart) begin
                        state_d = StFill;
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: straight from flops, no path from A to B
    // ------------------------------------------------------------------------
    always_comb begin
        B         = b_q;
        match_cnt = cnt_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       A;
    logic       cfg_load;
    logic [4:0] pattern;

    // dut0: defaults (OVERLAP=1, CNT_W=8)
    logic       b0;
    logic [7:0] cnt0;
    logic [1:0] st0;
    // dut1: OVERLAP=0
    logic       b1;
    logic [7:0] cnt1;
    logic [1:0] st1;
    // dut2: CNT_W=2, OVERLAP=1
    logic       b2;
    logic [1:0] cnt2;
    logic [1:0] st2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_param dut0 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .A         (A),
        .cfg_load  (cfg_load),
        .pattern   (pattern),
        .B         (b0),
        .match_cnt (cnt0),
        .state     (st0)
    );

    seq_detector_param #(.OVERLAP(1'b0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .A         (A),
        .cfg_load  (cfg_load),
        .pattern   (pattern),
        .B         (b1),
        .match_cnt (cnt1),
        .state     (st1)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .A         (A),
        .cfg_load  (cfg_load),
        .pattern   (pattern),
        .B         (b2),
        .match_cnt (cnt2),
        .state     (st2)
    );

    // Drive one sample, then look #1 after the edge that took it.
    task automatic step(input logic a, input logic e);
        A  = a;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        A     = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load(input logic [4:0] p);
        cfg_load = 1'b1;
        pattern  = p;
        A        = 1'b1;
        en       = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_b0 got %0b want 0", b0); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_st0 got %0d want 0", st0); end
        checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL reset_st1 got %0d want 0", st1); end
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %0d want 0", cnt2); end
    endtask

    // PAT_INIT 00100 with stream 0,0,1,0,0.
    task automatic test_basic();
        logic [4:0] stream = 5'b00100;
        logic [4:0] exp_b  = 5'b00001;               // indexed by step, bit 0 = last
        logic [1:0] exp_st0[5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        logic [1:0] exp_st1[5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(stream[4-i], 1'b1);
            checks++; if (b0 !== exp_b[4-i]) begin errors++; $display("FAIL basic_b0 step %0d got %0b want %0b", i, b0, exp_b[4-i]); end
            checks++; if (b1 !== exp_b[4-i]) begin errors++; $display("FAIL basic_b1 step %0d got %0b want %0b", i, b1, exp_b[4-i]); end
            checks++; if (st0 !== exp_st0[i]) begin errors++; $display("FAIL basic_st0 step %0d got %0d want %0d", i, st0, exp_st0[i]); end
            checks++; if (st1 !== exp_st1[i]) begin errors++; $display("FAIL basic_st1 step %0d got %0d want %0d", i, st1, exp_st1[i]); end
        end
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL basic_cnt0 got %0d want 1", cnt0); end
        checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL basic_cnt1 got %0d want 1", cnt1); end
        step(1'b1, 1'b1);
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %0b want 0", b0); end
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL basic_cnt0_hold got %0d want 1", cnt0); end
    endtask

    // Pattern 10101 with stream 1,0,1,0,1,0,1.
    task automatic test_overlap();
        logic [6:0] stream = 7'b1010101;
        logic       exp_b0[7] = '{0, 0, 0, 0, 1, 0, 1};
        logic       exp_b1[7] = '{0, 0, 0, 0, 1, 0, 0};
        load(5'b10101);
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL ovl_load_cnt0 got %0d want 0", cnt0); end
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL ovl_load_st0 got %0d want 0", st0); end
        for (int i = 0; i < 7; i++) begin
            step(stream[6-i], 1'b1);
            checks++; if (b0 !== exp_b0[i]) begin errors++; $display("FAIL ovl_b0 step %0d got %0b want %0b", i, b0, exp_b0[i]); end
            checks++; if (b1 !== exp_b1[i]) begin errors++; $display("FAIL ovl_b1 step %0d got %0b want %0b", i, b1, exp_b1[i]); end
        end
        checks++; if (cnt0 !== 8'd2) begin errors++; $display("FAIL ovl_cnt0 got %0d want 2", cnt0); end
        checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL ovl_cnt1 got %0d want 1", cnt1); end
        checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL ovl_st0 got %0d want 2", st0); end
        checks++; if (st1 !== 2'd1) begin errors++; $display("FAIL ovl_st1 got %0d want 1", st1); end
    endtask

    // Pattern 00000: the zeroed window must not count until five bits arrive.
    task automatic test_fill_gating();
        for (int r = 0; r < 2; r++) begin
            if (r == 1) do_reset();
            load(5'b00000);
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 1'b1);
                checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL gate_b0 round %0d step %0d got %0b want 0", r, i, b0); end
            end
        end
        step(1'b0, 1'b1);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL gate_fifth_b0 got %0b want 1", b0); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL gate_fifth_b1 got %0b want 1", b1); end
        step(1'b0, 1'b1);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL gate_sixth_b0 got %0b want 1", b0); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL gate_sixth_b1 got %0b want 0", b1); end
        checks++; if (cnt0 !== 8'd2) begin errors++; $display("FAIL gate_cnt0 got %0d want 2", cnt0); end
    endtask

    // en=0 freezes everything, even with A=1 presented.
    task automatic test_enable();
        do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL en_hold_b0 step %0d got %0b want 0", i, b0); end
            checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL en_hold_st0 step %0d got %0d want 1", i, st0); end
            checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL en_hold_cnt0 step %0d got %0d want 0", i, cnt0); end
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL en_early_b0 got %0b want 0", b0); end
        step(1'b0, 1'b1);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL en_match_b0 got %0b want 1", b0); end
        checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL en_match_st0 got %0d want 2", st0); end
        step(1'b0, 1'b0);
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL en_off_b0 got %0b want 0", b0); end
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL en_off_cnt0 got %0d want 1", cnt0); end
        checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL en_off_st0 got %0d want 2", st0); end
    endtask

    // Reload mid-stream discards buffered bits and the counter.
    task automatic test_load_mid();
        logic [7:0] stream = 8'b00100100;
        do_reset();
        for (int i = 0; i < 8; i++) step(stream[7-i], 1'b1);
        checks++; if (cnt0 !== 8'd2) begin errors++; $display("FAIL mid_pre_cnt0 got %0d want 2", cnt0); end
        checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL mid_pre_cnt1 got %0d want 1", cnt1); end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        load(5'b11111);
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL mid_load_cnt0 got %0d want 0", cnt0); end
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL mid_load_st0 got %0d want 0", st0); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL mid_load_b0 got %0b want 0", b0); end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            checks++; if (b0 !== (i == 4)) begin errors++; $display("FAIL mid_b0 step %0d got %0b want %0b", i, b0, (i == 4)); end
        end
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL mid_cnt0 got %0d want 1", cnt0); end
        checks++; if (st0 !== 2'd2) begin errors++; $display("FAIL mid_st0 got %0d want 2", st0); end
    endtask

    // Ten 1s against 11111: dut2's 2-bit counter must stop at 3.
    task automatic test_saturate();
        int m;
        load(5'b11111);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1);
            m = (k >= 5) ? k - 4 : 0;
            checks++; if (b2 !== (k >= 5)) begin errors++; $display("FAIL sat_b2 bit %0d got %0b want %0b", k, b2, (k >= 5)); end
            checks++; if (cnt2 !== 2'((m > 3) ? 3 : m)) begin errors++; $display("FAIL sat_cnt2 bit %0d got %0d want %0d", k, cnt2, (m > 3) ? 3 : m); end
            checks++; if (cnt0 !== 8'(m)) begin errors++; $display("FAIL sat_cnt0 bit %0d got %0d want %0d", k, cnt0, m); end
            checks++; if (b1 !== (k == 5 || k == 10)) begin errors++; $display("FAIL sat_b1 bit %0d got %0b want %0b", k, b1, (k == 5 || k == 10)); end
        end
        checks++; if (cnt1 !== 8'd2) begin errors++; $display("FAIL sat_cnt1 got %0d want 2", cnt1); end
        do_reset();
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL sat_rst_b2 got %0b want 0", b2); end
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL sat_rst_cnt2 got %0d want 0", cnt2); end
        checks++; if (st2 !== 2'd0) begin errors++; $display("FAIL sat_rst_st2 got %0d want 0", st2); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL sat_rst_b0 got %0b want 0", b0); end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        A        = 1'b0;
        cfg_load = 1'b0;
        pattern  = 5'b00000;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overlap();
        test_fill_gating();
        test_enable();
        test_load_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
